// File: rtl/master_arbiter.sv
// Serial-bus master front end: turns parallel device requests into LSB-first
// address/data bit streams, and arbitrates the bus between itself and a second master.
module master_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic [DATA_WIDTH-1:0] drdata,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic                  dvalid,
  output logic                  dready,
  input  logic                  dmode,
  input  logic                  mrdata,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  svalid,
  input  logic                  breq2,
  output logic                  bgrant1,
  output logic                  bgrant2,
  output logic                  breq1,
  output logic                  msel
);
  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);

  typedef enum logic [2:0] {M_IDLE, M_REQ, M_ADDR, M_WDATA, M_RWAIT} mst_e;
  typedef enum logic [1:0] {A_IDLE, A_M1, A_M2} arb_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  mode;
  } req_t;

  mst_e                  mst, mst_nxt;
  arb_e                  arb, arb_nxt;
  req_t                  req_q;
  logic [CW-1:0]         bcnt;
  logic [DATA_WIDTH-1:0] rsh;
  logic [DATA_WIDTH-1:0] rsh_nxt;
  logic                  addr_last, data_last;

  assign addr_last = (bcnt == CW'(ADDR_WIDTH - 1));
  assign data_last = (bcnt == CW'(DATA_WIDTH - 1));
  assign rsh_nxt   = {mrdata, rsh[DATA_WIDTH-1:1]};

  // All outputs decode registered state only.
  assign dready  = (mst == M_IDLE);
  assign breq1   = (mst != M_IDLE);
  assign mmode   = breq1 & req_q.mode;
  assign mvalid  = (mst == M_ADDR) || (mst == M_WDATA);
  assign mwdata  = (mst == M_ADDR)  ? req_q.addr[0] :
                   (mst == M_WDATA) ? req_q.data[0] : 1'b0;
  assign bgrant1 = (arb == A_M1);
  assign bgrant2 = (arb == A_M2);
  assign msel    = (arb == A_M2);

  // Master port FSM
  always_ff @(posedge clk) begin
    if (rstn) mst <= M_IDLE;
    else      mst <= mst_nxt;
  end

  always_comb begin
    mst_nxt = mst;
    case (mst)
      M_IDLE:  if (dvalid)              mst_nxt = M_REQ;
      M_REQ:   if (bgrant1)             mst_nxt = M_ADDR;
      M_ADDR:  if (addr_last)           mst_nxt = req_q.mode ? M_WDATA : M_RWAIT;
      M_WDATA: if (data_last)           mst_nxt = M_IDLE;
      M_RWAIT: if (svalid && data_last) mst_nxt = M_IDLE;
      default:                          mst_nxt = M_IDLE;
    endcase
  end

  // Shift registers drain LSB first; one counter serves every phase.
  always_ff @(posedge clk) begin
    if (rstn) begin
      req_q  <= '0;
      bcnt   <= '0;
      rsh    <= '0;
      drdata <= '0;
    end else begin
      case (mst)
        M_IDLE: if (dvalid) begin
          req_q <= {daddr, dwdata, dmode};
          bcnt  <= '0;
        end
        M_ADDR: begin
          req_q.addr <= req_q.addr >> 1;
          bcnt       <= addr_last ? '0 : bcnt + 1'b1;
        end
        M_WDATA: begin
          req_q.data <= req_q.data >> 1;
          bcnt       <= data_last ? '0 : bcnt + 1'b1;
        end
        M_RWAIT: if (svalid) begin
          rsh  <= rsh_nxt;
          bcnt <= data_last ? '0 : bcnt + 1'b1;
          if (data_last) drdata <= rsh_nxt;
        end
        default: ;
      endcase
    end
  end

  // Arbiter FSM: master 1 wins ties, no preemption, direct handover.
  always_ff @(posedge clk) begin
    if (rstn) arb <= A_IDLE;
    else      arb <= arb_nxt;
  end

  always_comb begin
    arb_nxt = arb;
    case (arb)
      A_IDLE: begin
        if (breq1)      arb_nxt = A_M1;
        else if (breq2) arb_nxt = A_M2;
      end
      A_M1:    if (!breq1) arb_nxt = breq2 ? A_M2 : A_IDLE;
      A_M2:    if (!breq2) arb_nxt = breq1 ? A_M1 : A_IDLE;
      default: arb_nxt = A_IDLE;
    endcase
  end

endmodule

// File: tb/tb_master_arbiter.sv
// Bench for master_arbiter: directed scenarios plus random transactions, checked
// against bit streams and latencies derived from the request fields.
module tb_master_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] dwdata, drdata;
  logic [AW-1:0] daddr;
  logic          dvalid, dready, dmode;
  logic          mrdata, mwdata, mmode, mvalid, svalid;
  logic          breq2, bgrant1, bgrant2, breq1, msel;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] last_rd = '0;

  always #5 clk = ~clk;

  master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .dwdata(dwdata), .drdata(drdata), .daddr(daddr),
    .dvalid(dvalid), .dready(dready), .dmode(dmode), .mrdata(mrdata),
    .mwdata(mwdata), .mmode(mmode), .mvalid(mvalid), .svalid(svalid),
    .breq2(breq2), .bgrant1(bgrant1), .bgrant2(bgrant2), .breq1(breq1), .msel(msel)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request and let the accepting edge pass.
  task automatic start_req(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t = 0;
    while (dready !== 1'b1 && t < 100) begin
      step();
      t++;
    end
    chk("dready_before_req", 32'(dready), 1);
    daddr = a; dwdata = d; dmode = m; dvalid = 1'b1;
    step();
    dvalid = 1'b0; daddr = ~a; dwdata = ~d; dmode = ~m;
    chk("accept_breq1", 32'(breq1), 1);
    chk("accept_dready", 32'(dready), 0);
    chk("accept_mmode", 32'(mmode), 32'(m));
  endtask

  task automatic wait_mvalid(output int lat);
    lat = 0;
    while (mvalid !== 1'b1 && lat < 200) begin
      chk("quiet_mwdata", 32'(mwdata), 0);
      step();
      lat++;
    end
    chk("mvalid_arrives", 32'(mvalid), 1);
  endtask

  task automatic collect(input int n, input logic m, output logic [AW+DW-1:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      chk("mvalid_run", 32'(mvalid), 1);
      chk("mmode_run", 32'(mmode), 32'(m));
      bits[i] = mwdata;
      step();
    end
  endtask

  // Slave returns d LSB first with idle gaps; junk on mrdata during gaps.
  task automatic read_data(input logic [DW-1:0] d);
    for (int i = 0; i < DW; i++) begin
      int g = (i % 3 == 0) ? 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 1));
      for (int k = 0; k < g; k++) begin
        svalid = 1'b0;
        mrdata = 1'($urandom);
        step();
        chk("rwait_dready", 32'(dready), 0);
        chk("rwait_mvalid", 32'(mvalid), 0);
      end
      svalid = 1'b1;
      mrdata = d[i];
      step();
      chk("rd_bit_dready", 32'(dready), (i == DW - 1) ? 1 : 0);
    end
    svalid = 1'b0;
    mrdata = 1'b0;
  endtask

  // Runs a transaction already accepted by start_req to completion.
  task automatic finish_txn(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int lat);
    logic [AW+DW-1:0] bits;
    wait_mvalid(lat);
    dvalid = 1'b1;
    collect(AW, m, bits);
    dvalid = 1'b0;
    chk("addr_stream", 32'(bits[AW-1:0]), 32'(a));
    if (m) begin
      collect(DW, m, bits);
      chk("wdata_stream", 32'(bits[DW-1:0]), 32'(d));
      chk("wr_done_dready", 32'(dready), 1);
      chk("wr_done_breq1", 32'(breq1), 0);
      chk("wr_done_mvalid", 32'(mvalid), 0);
      chk("drdata_kept", 32'(drdata), 32'(last_rd));
    end else begin
      chk("rwait_enter_mvalid", 32'(mvalid), 0);
      chk("rwait_enter_mwdata", 32'(mwdata), 0);
      read_data(d);
      chk("rd_drdata", 32'(drdata), 32'(d));
      chk("rd_done_breq1", 32'(breq1), 0);
      last_rd = d;
    end
  endtask

  task automatic run_txn(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int lat);
    start_req(m, a, d);
    finish_txn(m, a, d, lat);
  endtask

  initial begin
    int lat;
    logic [AW+DW-1:0] bits;
    rstn = 1'b1; dvalid = 1'b0; dmode = 1'b0; daddr = '0; dwdata = '0;
    mrdata = 1'b0; svalid = 1'b0; breq2 = 1'b0;

    // Reset state
    step(); step();
    chk("rst_dready", 32'(dready), 1);
    chk("rst_mvalid", 32'(mvalid), 0);
    chk("rst_breq1", 32'(breq1), 0);
    chk("rst_bgrant1", 32'(bgrant1), 0);
    chk("rst_bgrant2", 32'(bgrant2), 0);
    chk("rst_drdata", 32'(drdata), 0);
    chk("rst_mmode", 32'(mmode), 0);
    chk("rst_msel", 32'(msel), 0);
    rstn = 1'b0;
    step();

    // Write with idle second master: grant at T+1, ADDR at T+2
    start_req(1'b1, 16'h1234, 8'hAA);
    chk("wr_grant_T", 32'(bgrant1), 0);
    step();
    chk("wr_grant_T1", 32'(bgrant1), 1);
    chk("wr_msel_T1", 32'(msel), 0);
    finish_txn(1'b1, 16'h1234, 8'hAA, lat);
    chk("wr_addr_latency", lat, 1);
    chk("wr_grant_lingers", 32'(bgrant1), 1);
    step();
    chk("wr_grant_released", 32'(bgrant1), 0);

    // Read with gapped svalid
    run_txn(1'b0, 16'h00F0, 8'h5C, lat);
    chk("rd_latency", lat, 2);
    step();

    // Simultaneous requests: master 1 first, then direct handover
    start_req(1'b1, 16'hBEEF, 8'h3C);
    breq2 = 1'b1;
    step();
    chk("arb_bgrant1", 32'(bgrant1), 1);
    chk("arb_bgrant2", 32'(bgrant2), 0);
    chk("arb_msel0", 32'(msel), 0);
    finish_txn(1'b1, 16'hBEEF, 8'h3C, lat);
    chk("arb_latency", lat, 1);
    chk("arb_still_m1", 32'(bgrant1), 1);
    step();
    chk("arb_handover_g2", 32'(bgrant2), 1);
    chk("arb_handover_msel", 32'(msel), 1);
    chk("arb_handover_g1", 32'(bgrant1), 0);
    breq2 = 1'b0;
    step();
    chk("arb_g2_released", 32'(bgrant2), 0);
    chk("arb_msel_back", 32'(msel), 0);

    // No preemption of the external master
    breq2 = 1'b1;
    step();
    chk("np_bgrant2", 32'(bgrant2), 1);
    start_req(1'b1, 16'h8001, 8'h81);
    for (int i = 0; i < 4; i++) begin
      chk("np_breq1", 32'(breq1), 1);
      chk("np_mvalid", 32'(mvalid), 0);
      chk("np_bgrant1", 32'(bgrant1), 0);
      chk("np_bgrant2_held", 32'(bgrant2), 1);
      step();
    end
    breq2 = 1'b0;
    finish_txn(1'b1, 16'h8001, 8'h81, lat);
    chk("np_latency_after_drop", lat, 2);

    // Reset in the middle of the address phase
    start_req(1'b1, 16'hA5A5, 8'h0F);
    wait_mvalid(lat);
    collect(5, 1'b1, bits);
    chk("mr_partial_addr", 32'(bits[4:0]), 32'h05);
    rstn = 1'b1;
    step();
    chk("mr_mvalid", 32'(mvalid), 0);
    chk("mr_breq1", 32'(breq1), 0);
    chk("mr_dready", 32'(dready), 1);
    chk("mr_bgrant1", 32'(bgrant1), 0);
    chk("mr_drdata", 32'(drdata), 0);
    last_rd = '0;
    rstn = 1'b0;
    run_txn(1'b1, 16'h0FF0, 8'hC3, lat);
    chk("mr_recover_latency", lat, 2);

    // Random traffic with the second master idle
    for (int n = 0; n < 16; n++) begin
      logic          m = 1'($urandom);
      logic [AW-1:0] a = 16'($urandom);
      logic [DW-1:0] d = 8'($urandom);
      int            gap = int'($urandom_range(0, 3));
      for (int k = 0; k < gap; k++) step();
      run_txn(m, a, d, lat);
      chk("rand_latency", lat, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
